// File: rtl/k16_frame_buffer_arbiter_pkg.sv
// Shared K16 video constants and the CPU access FSM encoding.
package k16_frame_buffer_arbiter_pkg;

  localparam int unsigned COLUMNS     = 40;
  localparam int unsigned ROWS        = 30;
  localparam int unsigned CLEAR_WORDS = COLUMNS * ROWS;
  localparam int unsigned ADDR_WIDTH  = 11;
  localparam int unsigned DEPTH       = 2048;
  localparam int unsigned DATA_WIDTH  = 16;

  localparam logic [1:0] CPU_IDLE   = 2'd0;
  localparam logic [1:0] CPU_ACCESS = 2'd1;
  localparam logic [1:0] CPU_ACK    = 2'd2;

endpackage

// File: rtl/k16_frame_buffer_arbiter_if.sv
// Video, CPU and clear request/response signals of the frame buffer arbiter.
interface k16_frame_buffer_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] video_addr;
  logic                  video_want_read;
  logic [15:0]           video_data;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [15:0]           cpu_wdata;
  logic [15:0]           cpu_rdata;
  logic                  cpu_ack;

  logic                  clear_start;
  logic [15:0]           clear_value;
  logic                  clear_busy;

  modport master (
    output video_addr, video_want_read,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output clear_start, clear_value,
    input  video_data, cpu_rdata, cpu_ack, clear_busy
  );

  modport slave (
    input  video_addr, video_want_read,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  clear_start, clear_value,
    output video_data, cpu_rdata, cpu_ack, clear_busy
  );
endinterface

// File: rtl/k16_frame_buffer_ram.sv
// Single-port synchronous frame buffer RAM, one access per cycle, 1-cycle read latency.
module k16_frame_buffer_ram #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         idx;

  // Addresses wrap modulo DEPTH so any address is a legal word.
  assign idx = IW'(32'(addr) % DEPTH);

  // Write or read the selected word; rdata only moves on reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/k16_frame_buffer_arbiter.sv
// Frame buffer arbiter: video > clear > CPU on one single-port RAM.
module k16_frame_buffer_arbiter #(
  parameter int unsigned ADDR_WIDTH  = k16_frame_buffer_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH       = k16_frame_buffer_arbiter_pkg::DEPTH,
  parameter int unsigned CLEAR_WORDS = k16_frame_buffer_arbiter_pkg::CLEAR_WORDS
) (
  input logic                        clk,
  input logic                        reset,
  k16_frame_buffer_arbiter_if.slave  bus
);

  import k16_frame_buffer_arbiter_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(CLEAR_WORDS - 1);

  logic [1:0]            state_q, state_d;
  logic                  cpu_we_q, cpu_we_d;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
  logic [15:0]           cpu_wdata_q, cpu_wdata_d;

  logic                  clr_busy_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [15:0]           clr_val_q;

  logic                  vid_rd_q;
  logic                  cpu_rd_q;
  logic [15:0]           video_hold_q;
  logic [15:0]           cpu_rdata_q;

  logic                  vid_gnt, clr_gnt, cpu_gnt;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_wdata, ram_rdata;

  // Fixed priority: video never stalls, clear beats the CPU.
  assign vid_gnt   = bus.video_want_read;
  assign clr_gnt   = !vid_gnt && clr_busy_q;
  assign cpu_gnt   = !vid_gnt && !clr_busy_q && (state_q == CPU_ACCESS);

  // Reset blocks every RAM access so an aborted operation leaves memory alone.
  assign ram_en    = !reset && (vid_gnt || clr_gnt || cpu_gnt);
  assign ram_we    = clr_gnt || (cpu_gnt && cpu_we_q);
  assign ram_addr  = vid_gnt ? bus.video_addr : (clr_gnt ? clr_cnt_q : cpu_addr_q);
  assign ram_wdata = clr_gnt ? clr_val_q : cpu_wdata_q;

  k16_frame_buffer_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (16)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // CPU access FSM next state and command latch.
  always_comb begin
    state_d     = state_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    case (state_q)
      CPU_IDLE: begin
        if (bus.cpu_req) begin
          state_d     = CPU_ACCESS;
          cpu_we_d    = bus.cpu_we;
          cpu_addr_d  = bus.cpu_addr;
          cpu_wdata_d = bus.cpu_wdata;
        end
      end
      CPU_ACCESS: begin
        if (cpu_gnt) begin
          state_d = CPU_ACK;
        end
      end
      CPU_ACK: state_d = CPU_IDLE;
      default: state_d = CPU_IDLE;
    endcase
  end

  // CPU FSM state and latched command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CPU_IDLE;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_we_q    <= cpu_we_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
    end
  end

  // Clear engine: one word per cycle not taken by video; new starts ignored while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_busy_q <= 1'b0;
      clr_cnt_q  <= '0;
      clr_val_q  <= '0;
    end else if (!clr_busy_q) begin
      if (bus.clear_start) begin
        clr_busy_q <= 1'b1;
        clr_cnt_q  <= '0;
        clr_val_q  <= bus.clear_value;
      end
    end else if (clr_gnt) begin
      if (clr_cnt_q == CLEAR_LAST) begin
        clr_busy_q <= 1'b0;
      end else begin
        clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Track which requester owns the RAM read data and hold the last value per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_rd_q     <= 1'b0;
      cpu_rd_q     <= 1'b0;
      video_hold_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      vid_rd_q <= vid_gnt;
      cpu_rd_q <= cpu_gnt && !cpu_we_q;
      if (vid_rd_q) begin
        video_hold_q <= ram_rdata;
      end
      if (cpu_rd_q) begin
        cpu_rdata_q <= ram_rdata;
      end
    end
  end

  // Fresh RAM data is forwarded in the cycle after a read, held value otherwise.
  assign bus.video_data = vid_rd_q ? ram_rdata : video_hold_q;
  assign bus.cpu_rdata  = cpu_rd_q ? ram_rdata : cpu_rdata_q;
  assign bus.cpu_ack    = (state_q == CPU_ACK);
  assign bus.clear_busy = clr_busy_q;

endmodule

// File: doc/k16_frame_buffer_arbiter.md
K16_FRAME_BUFFER_ARBITER -- requirements
Module: k16_frame_buffer_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the word-address width.
REQ-002 Parameter DEPTH, default 2048, SHALL set the number of 16-bit RAM words.
REQ-003 Parameter CLEAR_WORDS, default 1200 (40 columns x 30 rows), SHALL set the number of words a clear writes.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 video_addr  in  11  video read address, sampled when video_want_read=1.
REQ-007 video_want_read  in  1  video read request; may be high on consecutive cycles.
REQ-008 video_data  out  16  video read data.
REQ-009 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-010 cpu_we  in  1  1=write, 0=read; valid with cpu_req.
REQ-011 cpu_addr  in  11  CPU word address.
REQ-012 cpu_wdata  in  16  CPU write data.
REQ-013 cpu_rdata  out  16  CPU read data, valid when cpu_ack=1.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 clear_start  in  1  one-cycle pulse to fill words 0..CLEAR_WORDS-1.
REQ-016 clear_value  in  16  fill word, sampled on clear_start.
REQ-017 clear_busy  out  1  high while a clear is in progress.

Function
REQ-018 Storage SHALL be one single-port synchronous RAM, DEPTH x 16, one access per cycle, 1-cycle read latency.
REQ-019 Port priority per cycle SHALL be video > clear > CPU; video is never stalled.
REQ-020 On each cycle with video_want_read=1, RAM SHALL read video_addr; video_data SHALL update on the next edge.
REQ-021 video_data SHALL hold its last value on all cycles not following a video read.
REQ-022 CPU FSM states SHALL be IDLE, ACCESS, ACK.
REQ-023 IDLE->ACCESS on cpu_req=1; cpu_addr, cpu_we, cpu_wdata latched.
REQ-024 ACCESS SHALL perform the latched access in the first cycle where video_want_read=0 and clear_busy=0, then go to ACK.
REQ-025 ACK SHALL assert cpu_ack for exactly one cycle, present read data on cpu_rdata (write: cpu_rdata unchanged), then return to IDLE.
REQ-026 Minimum CPU latency SHALL be 2 cycles from cpu_req to cpu_ack; CPU SHALL drop cpu_req in the ack cycle, else a new request is accepted in the following IDLE cycle.
REQ-027 clear_start SHALL set clear_busy on the next edge, clear counter=0, latch clear_value.
REQ-028 Clear SHALL write one word per cycle not taken by video, counter incrementing by 1; clear_busy SHALL fall on the edge after writing word CLEAR_WORDS-1.
REQ-029 clear_start while clear_busy=1 SHALL be ignored.
REQ-030 CPU access latched in ACCESS during a clear SHALL wait until clear completes.
REQ-031 Addresses SHALL be used modulo DEPTH; no out-of-range error.
REQ-032 Simultaneous cpu_req and clear_start in IDLE: both latched; clear wins the RAM.

Reset
REQ-033 Reset SHALL set CPU FSM=IDLE, cpu_ack=0, cpu_rdata=0, video_data=0, clear_busy=0, clear counter=0.
REQ-034 Reset mid-clear or mid-CPU-access SHALL abort without further RAM writes; RAM contents SHALL not be reset.

Structure
REQ-035 A shared K16 video package SHALL hold ADDR_WIDTH, DEPTH, CLEAR_WORDS, COLUMNS=40, ROWS=30 and the CPU FSM state encoding.
REQ-036 The RAM SHALL be one sub-module, k16_frame_buffer_ram (single-port, synchronous read/write); arbitration, FSM and clear counter live in the top.

Verification
REQ-037 CPU write 0x1234 to 0x005, then read 0x005, no video -> cpu_ack 2 cycles after each cpu_req; read cpu_rdata=0x1234.
REQ-038 CPU write 0xABCD to 0x010 with video_want_read=1 for 4 cycles -> ack delayed 4 cycles; video_data continuous; read-back 0xABCD.
REQ-039 Video reads 0x010 then 0x011 on consecutive cycles -> video_data=mem[0x010] then mem[0x011] on the two following cycles, then held.
REQ-040 clear_start with clear_value=0x0720, no video -> clear_busy high exactly 1200 cycles; words 0..1199=0x0720, word 1200 unchanged.
REQ-041 clear with video_want_read 2 of every 16 cycles and CPU read of 0x000 pending -> clear_busy 1372 cycles (1200 + 172 stolen cycles); CPU ack after clear with cpu_rdata=0x0720.
REQ-042 Reset asserted at clear counter 500 -> clear_busy=0 next edge; words 500..1199 retain prior values.
